// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan path: digit limits,
// digit-enable polarity constants and a width helper.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  // Digit-select polarity, shared with the decoder top.
  localparam bit DIGIT_EN_ACTIVE_LOW  = 1'b1;
  localparam bit DIGIT_EN_ACTIVE_HIGH = 1'b0;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Value/display bundle between the value source and the scan multiplexer.
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] i_value;
  logic                    i_load;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic                    i_blank_lz;
  logic [3:0]              o_nibble;
  logic                    o_dp;
  logic [NUM_DIGITS-1:0]   o_digit_en;
  logic                    o_frame_done;

  modport master (
    output i_value, i_load, i_dp, i_blank_lz,
    input  o_nibble, o_dp, o_digit_en, o_frame_done
  );

  modport slave (
    input  i_value, i_load, i_dp, i_blank_lz,
    output o_nibble, o_dp, o_digit_en, o_frame_done
  );

endinterface

// File: rtl/seg7_slot_timer.sv
// Slot timer: counts cycles within a digit slot and steps the digit
// index on every slot wrap; flags the last cycle of the last slot.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter  int TICKS      = 10,
  parameter  int NUM_DIGITS = 4,
  localparam int CW         = clog2_min1(TICKS),
  localparam int IW         = clog2_min1(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic [IW-1:0] idx,
  output logic          boundary
);

  localparam logic [CW-1:0] CNT_MAX = CW'(TICKS - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic wrap;

  assign wrap     = (cnt == CNT_MAX);
  assign boundary = wrap && (idx == IDX_MAX);

  // Slot counter and digit index; index wraps back to digit 0 after the last slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit 7-segment scan multiplexer: holds a double-buffered hex value,
// presents one nibble per slot with blanking, leading-zero suppression
// and frame-synchronous value updates. All outputs are registered.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int DIGIT_RATE_HZ    = 1000,
  parameter int BLANK_CYCLES     = 16,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input logic            i_clk,
  input logic            i_rst_n,
  seg7_scan_mux_if.slave bus
);

  localparam int TICKS = CLK_FREQ_HZ / DIGIT_RATE_HZ;
  localparam int CW    = clog2_min1(TICKS);
  localparam int IW    = clog2_min1(NUM_DIGITS);
  localparam bit ACT_LOW = (DIGIT_ACTIVE_LOW != 0) ? DIGIT_EN_ACTIVE_LOW : DIGIT_EN_ACTIVE_HIGH;
  localparam logic [CW-1:0]         BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] EN_OFF    = ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  if (BLANK_CYCLES >= TICKS) begin : g_bad_blank
    $error("seg7_scan_mux: BLANK_CYCLES must be smaller than the slot length");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("seg7_scan_mux: NUM_DIGITS out of range 1..8");
  end

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          boundary;

  seg7_slot_timer #(
    .TICKS      (TICKS),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .cnt      (cnt),
    .idx      (idx),
    .boundary (boundary)
  );

  logic [NUM_DIGITS-1:0][3:0] disp_val;
  logic [NUM_DIGITS-1:0]      disp_dp;
  logic [NUM_DIGITS-1:0][3:0] pend_val;
  logic [NUM_DIGITS-1:0]      pend_dp;
  logic                       pend_vld;

  // Double buffer: loads land in pending; display only changes at a frame
  // boundary, where a coincident load bypasses pending so it is not delayed a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      disp_val <= '0;
      disp_dp  <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
    end else if (boundary && bus.i_load) begin
      disp_val <= bus.i_value;
      disp_dp  <= bus.i_dp;
      pend_vld <= 1'b0;
    end else begin
      if (boundary && pend_vld) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        pend_vld <= 1'b0;
      end
      if (bus.i_load) begin
        pend_val <= bus.i_value;
        pend_dp  <= bus.i_dp;
        pend_vld <= 1'b1;
      end
    end
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] lz;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] show;
  logic [NUM_DIGITS-1:0] en_next;

  // Select the current digit and find digits that are leading zeros
  // (this and every higher nibble zero, no decimal point on this digit).
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    sel        = '0;
    lz         = '0;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = disp_val[i];
        cur_dp  = disp_dp[i];
        sel[i]  = 1'b1;
      end
    end
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (disp_val[i] == 4'h0);
      lz[i]      = upper_zero && !disp_dp[i];
    end
    show    = (cnt >= BLANK_END) ? (sel & ~(lz & {NUM_DIGITS{bus.i_blank_lz}})) : '0;
    en_next = ACT_LOW ? ~show : show;
  end

  // Output register stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_nibble     <= 4'h0;
      bus.o_dp         <= 1'b0;
      bus.o_digit_en   <= EN_OFF;
      bus.o_frame_done <= 1'b0;
    end else begin
      bus.o_nibble     <= cur_nib;
      bus.o_dp         <= cur_dp;
      bus.o_digit_en   <= en_next;
      bus.o_frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: 4-digit and 1-digit instances, TICKS=10,
// BLANK_CYCLES=2, active-low digit enables.
module tb_seg7_scan_mux;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic [3:0] en;
    logic       fd;
  } exp4_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       en;
    logic       fd;
  } exp1_t;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_bad = 0;
  int s_since_rst = 0;

  exp4_t q4[$];
  exp1_t q1[$];

  seg7_scan_mux_if #(.NUM_DIGITS(4)) bus4 ();
  seg7_scan_mux_if #(.NUM_DIGITS(1)) bus1 ();

  seg7_scan_mux #(
    .NUM_DIGITS       (4),
    .CLK_FREQ_HZ      (1000),
    .DIGIT_RATE_HZ    (100),
    .BLANK_CYCLES     (2),
    .DIGIT_ACTIVE_LOW (1)
  ) u_dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus4.slave)
  );

  seg7_scan_mux #(
    .NUM_DIGITS       (1),
    .CLK_FREQ_HZ      (1000),
    .DIGIT_RATE_HZ    (100),
    .BLANK_CYCLES     (2),
    .DIGIT_ACTIVE_LOW (1)
  ) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every output cycle out of reset is popped and compared.
  always @(posedge clk) begin
    exp4_t e4, a4;
    exp1_t e1, a1;
    #1;
    if (rst_n) begin
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        a4 = '{bus4.o_nibble, bus4.o_dp, bus4.o_digit_en, bus4.o_frame_done};
        n_cmp++;
        if (a4 !== e4) begin
          n_bad++;
          $display("FAIL scan4 t=%0t: got nib=%h dp=%b en=%b fd=%b, want nib=%h dp=%b en=%b fd=%b",
                   $time, a4.nib, a4.dp, a4.en, a4.fd, e4.nib, e4.dp, e4.en, e4.fd);
        end
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        a1 = '{bus1.o_nibble, bus1.o_dp, bus1.o_digit_en, bus1.o_frame_done};
        n_cmp++;
        if (a1 !== e1) begin
          n_bad++;
          $display("FAIL scan1 t=%0t: got nib=%h dp=%b en=%b fd=%b, want nib=%h dp=%b en=%b fd=%b",
                   $time, a1.nib, a1.dp, a1.en, a1.fd, e1.nib, e1.dp, e1.en, e1.fd);
        end
      end
    end
  end

  // Drive one frame (or its first ncyc cycles) starting at slot 0 cycle 0.
  // d/dp: value expected on display this frame; vis: digits expected lit
  // after blanking; lc0/lc1: frame cycles carrying a load (-1 = none).
  task automatic run_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] vis,
                           input logic lz, input int ncyc, input int lc0, input int lc1,
                           input logic [15:0] lv0, input logic [15:0] lv1, input logic [3:0] ldp);
    for (int c = 0; c < ncyc; c++) begin
      int    di;
      int    cnt;
      exp4_t e;
      exp1_t e1;
      di  = c / 10;
      cnt = c % 10;
      bus4.i_blank_lz = lz;
      bus4.i_load     = (c == lc0) || (c == lc1);
      bus4.i_value    = (c == lc1) ? lv1 : lv0;
      bus4.i_dp       = ldp;
      e.nib = d[di*4 +: 4];
      e.dp  = dp[di];
      e.en  = (cnt < 2 || !vis[di]) ? 4'b1111 : ~(4'b0001 << di);
      e.fd  = (c == 39);
      q4.push_back(e);
      e1.nib = (s_since_rst >= 10) ? 4'h9 : 4'h0;
      e1.dp  = 1'b0;
      e1.en  = ((s_since_rst % 10) < 2);
      e1.fd  = ((s_since_rst % 10) == 9);
      q1.push_back(e1);
      s_since_rst++;
      @(negedge clk);
    end
    bus4.i_load = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b1;
    bus4.i_value    = '0;
    bus4.i_load     = 1'b0;
    bus4.i_dp       = '0;
    bus4.i_blank_lz = 1'b0;
    bus1.i_value    = 4'h9;
    bus1.i_load     = 1'b1;
    bus1.i_dp       = 1'b0;
    bus1.i_blank_lz = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_en4",  32'(bus4.o_digit_en),   32'h0000000F);
    check("reset_nib4", 32'(bus4.o_nibble),     32'h0);
    check("reset_dp4",  32'(bus4.o_dp),         32'h0);
    check("reset_fd4",  32'(bus4.o_frame_done), 32'h0);
    check("reset_en1",  32'(bus1.o_digit_en),   32'h1);

    rst_n = 1'b1;
    s_since_rst = 0;
    // Reset display shows zeros; 1A2F loaded at cycle 0 waits for the boundary.
    run_frame(16'h0000, 4'b0000, 4'b1111, 1'b0, 40,  0, -1, 16'h1A2F, 16'h0000, 4'b0000);
    // 1A2F shown; 0005 loaded on the boundary cycle itself.
    run_frame(16'h1A2F, 4'b0000, 4'b1111, 1'b0, 40, 39, -1, 16'h0005, 16'h0000, 4'b0000);
    // Leading zeros suppressed: only digit 0 lit.
    run_frame(16'h0005, 4'b0000, 4'b0001, 1'b1, 40,  5, -1, 16'h0105, 16'h0000, 4'b0000);
    // 0105: only digit 3 suppressed; two loads, last wins.
    run_frame(16'h0105, 4'b0000, 4'b0111, 1'b1, 40,  3, 20, 16'h1111, 16'h2222, 4'b1001);
    // 2222 with decimal points on digits 0 and 3.
    run_frame(16'h2222, 4'b1001, 4'b1111, 1'b0, 40, 10, -1, 16'h0000, 16'h0000, 4'b0100);
    // All zero, dp on digit 2 keeps it lit; digits 1 and 3 suppressed.
    run_frame(16'h0000, 4'b0100, 4'b0101, 1'b1, 40,  0, -1, 16'h1234, 16'h0000, 4'b0000);
    // 1234 up to digit 2 cycle 3; 7777 goes pending and is lost to reset.
    run_frame(16'h1234, 4'b0000, 4'b1111, 1'b0, 24, 22, -1, 16'h7777, 16'h0000, 4'b0000);

    #2 rst_n = 1'b0;
    #1;
    check("midrst_en4",  32'(bus4.o_digit_en),   32'h0000000F);
    check("midrst_nib4", 32'(bus4.o_nibble),     32'h0);
    check("midrst_dp4",  32'(bus4.o_dp),         32'h0);
    check("midrst_fd4",  32'(bus4.o_frame_done), 32'h0);
    check("midrst_en1",  32'(bus1.o_digit_en),   32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_since_rst = 0;
    run_frame(16'h0000, 4'b0000, 4'b1111, 1'b0, 40, -1, -1, 16'h0000, 16'h0000, 4'b0000);
    run_frame(16'h0000, 4'b0000, 4'b1111, 1'b0, 20, -1, -1, 16'h0000, 16'h0000, 4'b0000);

    @(posedge clk);
    #3;
    check("q4_drained", 32'(q4.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
